// File: rtl/cache_fill_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_responder_if
//  Description : Write-back / read-fill handshake bundle between the cache
//                (master) and the memory-side fill responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_responder_if #(
   parameter int ADDR_BITS = 32,
   parameter int LINE_BITS = 512
);
   // Write-back channel
   logic                 wr_back_val;
   logic [ADDR_BITS-1:0] wr_back_addr;
   logic [LINE_BITS-1:0] wr_back_data;
   logic                 wr_back_rdy;

   // Read-fill request channel
   logic                 fill_req_val;
   logic [ADDR_BITS-1:0] fill_req_addr;
   logic                 fill_req_rdy;

   // Fill data return channel
   logic                 rd_fill_en;
   logic [LINE_BITS-1:0] fill_data;
   logic                 data_in_rdy;

   // Status
   logic                 busy;

   modport master (
      output wr_back_val, wr_back_addr, wr_back_data,
      output fill_req_val, fill_req_addr,
      output data_in_rdy,
      input  wr_back_rdy, fill_req_rdy, rd_fill_en, fill_data, busy
   );

   modport slave (
      input  wr_back_val, wr_back_addr, wr_back_data,
      input  fill_req_val, fill_req_addr,
      input  data_in_rdy,
      output wr_back_rdy, fill_req_rdy, rd_fill_en, fill_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/cache_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_responder
//  Description : Memory-side responder for cache miss traffic. Accepts
//                dirty-line write-backs and read-fill requests, services them
//                from a line-granular backing store with fixed latencies and
//                returns fill data over the cache fill handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_responder #(
   parameter int ADDR_BITS = 32,
   parameter int LINE_BITS = 512,
   parameter int OFFS_BITS = 6,
   parameter int MEM_LINES = 1024,
   parameter int RD_LAT    = 4,
   parameter int WR_LAT    = 2
) (
   input  wire logic                i_clk,
   input  wire logic                i_rst_n,
   cache_fill_responder_if.slave    bus
);

   localparam int IDX_BITS = $clog2(MEM_LINES);
   localparam int MAX_LAT  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_BITS = $clog2(MAX_LAT + 1);

   localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(RD_LAT - 1);
   localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WR_LAT - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WB_WAIT = 3'd1,
      S_WB_DONE = 3'd2,
      S_RD_WAIT = 3'd3,
      S_FILL    = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_BITS-1:0]  r_cnt;
   logic [CNT_BITS-1:0]  w_cnt_nxt;
   logic                 r_wb_rdy;
   logic                 r_rd_fill_en;
   logic [LINE_BITS-1:0] r_fill_data;

   logic                 w_wb_accept;
   logic                 w_fill_accept;
   logic [IDX_BITS-1:0]  w_wb_idx;
   logic [IDX_BITS-1:0]  w_fill_idx;
   logic                 w_unused_addr_bits;

   // Backing store: intentionally has no reset so contents survive rst_n.
   logic [LINE_BITS-1:0] r_mem [MEM_LINES];

   // Offset bits and bits above the line index are ignored (aliasing).
   assign w_wb_idx   = bus.wr_back_addr[OFFS_BITS +: IDX_BITS];
   assign w_fill_idx = bus.fill_req_addr[OFFS_BITS +: IDX_BITS];
   assign w_unused_addr_bits = ^{bus.wr_back_addr, bus.fill_req_addr};

   // Write-back wins over a simultaneous fill request.
   assign w_wb_accept   = (r_state == S_IDLE) && bus.wr_back_val;
   assign w_fill_accept = (r_state == S_IDLE) && !bus.wr_back_val && bus.fill_req_val;

   // Store write happens at the accept edge; suppressed while reset is held.
   always_ff @(posedge i_clk) begin
      if (w_wb_accept && i_rst_n) begin
         r_mem[w_wb_idx] <= bus.wr_back_data;
      end
   end

   // Next-state and latency counter decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.wr_back_val) begin
               w_cnt_nxt   = WR_LOAD;
               w_state_nxt = (WR_LAT == 1) ? S_WB_DONE : S_WB_WAIT;
            end else if (bus.fill_req_val) begin
               w_cnt_nxt   = RD_LOAD;
               w_state_nxt = (RD_LAT == 1) ? S_FILL : S_RD_WAIT;
            end
         end
         S_WB_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_WB_DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         S_WB_DONE: begin
            w_state_nxt = S_IDLE;
         end
         S_RD_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_FILL;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         S_FILL: begin
            if (bus.data_in_rdy) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; outputs follow the next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wb_rdy     <= 1'b0;
         r_rd_fill_en <= 1'b0;
         r_fill_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wb_rdy     <= (w_state_nxt == S_WB_DONE);
         r_rd_fill_en <= (w_state_nxt == S_FILL);
         if (w_fill_accept) begin
            r_fill_data <= r_mem[w_fill_idx];
         end
      end
   end

   assign bus.wr_back_rdy  = r_wb_rdy;
   assign bus.rd_fill_en   = r_rd_fill_en;
   assign bus.fill_data    = r_fill_data;
   assign bus.fill_req_rdy = (r_state == S_IDLE) && !bus.wr_back_val && i_rst_n;
   assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_responder
//  Description : Directed self-checking bench for cache_fill_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_responder;

   localparam int ADDR_BITS = 32;
   localparam int LINE_BITS = 512;
   localparam int RD_LAT    = 4;
   localparam int WR_LAT    = 2;

   localparam logic [LINE_BITS-1:0] D_A5   = {64{8'hA5}};
   localparam logic [LINE_BITS-1:0] D_1234 = 512'h1234;
   localparam logic [LINE_BITS-1:0] D_AL1  = 512'hDEAD_BEEF_0001;
   localparam logic [LINE_BITS-1:0] D_AL2  = {16{32'hCAFE_F00D}};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_fill_responder_if #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS)) bus ();

   cache_fill_responder #(
      .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .OFFS_BITS(6),
      .MEM_LINES(1024), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Observations filled by the transaction drivers
   int                   wb_lat, wb_len, wb_busy_pre;
   logic                 wb_end_busy;
   int                   fl_lat, fl_len;
   logic [LINE_BITS-1:0] fl_data;
   logic                 fl_stable, fl_leak, fl_rdy_before, fl_end_busy, fl_end_rdy;

   // Drive one write-back and record pulse timing (n = samples after accept edge)
   task automatic run_wb(input logic [ADDR_BITS-1:0] a, input logic [LINE_BITS-1:0] d);
      wb_lat = -1; wb_len = 0; wb_busy_pre = 0; wb_end_busy = 1'b1;
      bus.wr_back_val  = 1'b1;
      bus.wr_back_addr = a;
      bus.wr_back_data = d;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (bus.wr_back_rdy) begin
            if (wb_lat < 0) begin
               wb_lat = n;
               bus.wr_back_val = 1'b0;
            end
            wb_len++;
         end else if (wb_lat >= 0) begin
            wb_end_busy = bus.busy;
            break;
         end else if (bus.busy) begin
            wb_busy_pre++;
         end
      end
      bus.wr_back_val = 1'b0;
   endtask

   // Drive one fill; DataInRdy is held low for 'hold' cycles of RdFillEn
   task automatic run_fill(input logic [ADDR_BITS-1:0] a, input int hold);
      fl_lat = -1; fl_len = 0; fl_stable = 1'b1; fl_leak = 1'b0;
      fl_end_busy = 1'b1; fl_end_rdy = 1'b0; fl_data = '0;
      bus.fill_req_val  = 1'b1;
      bus.fill_req_addr = a;
      bus.data_in_rdy   = 1'b0;
      #1;
      fl_rdy_before = bus.fill_req_rdy;
      @(posedge clk); #1;
      bus.fill_req_val = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (bus.rd_fill_en) begin
            if (fl_lat < 0) begin
               fl_lat  = n;
               fl_data = bus.fill_data;
            end else if (bus.fill_data !== fl_data) begin
               fl_stable = 1'b0;
            end
            fl_len++;
            if (fl_len > hold) bus.data_in_rdy = 1'b1;
         end else if (fl_lat >= 0) begin
            fl_end_busy = bus.busy;
            fl_end_rdy  = bus.fill_req_rdy;
            break;
         end
         if (bus.fill_req_rdy) fl_leak = 1'b1;
         @(posedge clk); #1;
      end
      bus.data_in_rdy = 1'b0;
   endtask

   task automatic test_reset();
      bus.fill_req_val = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.rd_fill_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_fill_en: got %b expected 0", bus.rd_fill_en); end
      tests_run++;
      if (bus.wr_back_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_back_rdy: got %b expected 0", bus.wr_back_rdy); end
      tests_run++;
      if (bus.fill_data !== '0) begin tests_failed++; $display("FAIL reset_fill_data: got %h expected 0", bus.fill_data); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.fill_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_fill_req_rdy: got %b expected 0", bus.fill_req_rdy); end
      bus.fill_req_val = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_writeback();
      run_wb(32'h0000_0040, D_A5);
      tests_run++;
      if (wb_lat !== WR_LAT) begin tests_failed++; $display("FAIL wb_latency: got %0d expected %0d", wb_lat, WR_LAT); end
      tests_run++;
      if (wb_len !== 1) begin tests_failed++; $display("FAIL wb_pulse_width: got %0d expected 1", wb_len); end
      tests_run++;
      if (wb_busy_pre !== WR_LAT) begin tests_failed++; $display("FAIL wb_busy_cycles: got %0d expected %0d", wb_busy_pre, WR_LAT); end
      tests_run++;
      if (wb_end_busy !== 1'b0) begin tests_failed++; $display("FAIL wb_end_busy: got %b expected 0", wb_end_busy); end
   endtask

   task automatic test_fill_fast();
      run_fill(32'h0000_0040, 0);
      tests_run++;
      if (fl_rdy_before !== 1'b1) begin tests_failed++; $display("FAIL fast_req_rdy: got %b expected 1", fl_rdy_before); end
      tests_run++;
      if (fl_lat !== RD_LAT) begin tests_failed++; $display("FAIL fast_latency: got %0d expected %0d", fl_lat, RD_LAT); end
      tests_run++;
      if (fl_len !== 1) begin tests_failed++; $display("FAIL fast_en_width: got %0d expected 1", fl_len); end
      tests_run++;
      if (fl_data !== D_A5) begin tests_failed++; $display("FAIL fast_data: got %h expected %h", fl_data, D_A5); end
      tests_run++;
      if (fl_end_busy !== 1'b0) begin tests_failed++; $display("FAIL fast_end_busy: got %b expected 0", fl_end_busy); end
   endtask

   task automatic test_fill_stall();
      run_fill(32'h0000_0040, 7);
      tests_run++;
      if (fl_lat !== RD_LAT) begin tests_failed++; $display("FAIL stall_latency: got %0d expected %0d", fl_lat, RD_LAT); end
      tests_run++;
      if (fl_len !== 8) begin tests_failed++; $display("FAIL stall_en_width: got %0d expected 8", fl_len); end
      tests_run++;
      if (fl_stable !== 1'b1) begin tests_failed++; $display("FAIL stall_data_stable: got %b expected 1", fl_stable); end
      tests_run++;
      if (fl_data !== D_A5) begin tests_failed++; $display("FAIL stall_data: got %h expected %h", fl_data, D_A5); end
      tests_run++;
      if (fl_leak !== 1'b0) begin tests_failed++; $display("FAIL stall_req_rdy_while_busy: got %b expected 0", fl_leak); end
      tests_run++;
      if (fl_end_rdy !== 1'b1) begin tests_failed++; $display("FAIL stall_idle_after: got %b expected 1", fl_end_rdy); end
   endtask

   task automatic test_priority();
      bus.fill_req_val  = 1'b1;
      bus.fill_req_addr = 32'h0000_0080;
      bus.wr_back_val   = 1'b1;
      bus.wr_back_addr  = 32'h0000_0080;
      bus.wr_back_data  = D_1234;
      #1;
      tests_run++;
      if (bus.fill_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL prio_req_rdy: got %b expected 0", bus.fill_req_rdy); end
      run_wb(32'h0000_0080, D_1234);
      tests_run++;
      if (wb_lat !== WR_LAT) begin tests_failed++; $display("FAIL prio_wb_latency: got %0d expected %0d", wb_lat, WR_LAT); end
      run_fill(32'h0000_0080, 0);
      tests_run++;
      if (fl_rdy_before !== 1'b1) begin tests_failed++; $display("FAIL prio_fill_rdy_after_wb: got %b expected 1", fl_rdy_before); end
      tests_run++;
      if (fl_lat !== RD_LAT) begin tests_failed++; $display("FAIL prio_fill_latency: got %0d expected %0d", fl_lat, RD_LAT); end
      tests_run++;
      if (fl_data !== D_1234) begin tests_failed++; $display("FAIL prio_fill_data: got %h expected %h", fl_data, D_1234); end
   endtask

   task automatic test_alias();
      run_wb(32'h0001_007F, D_AL1);
      run_fill(32'h0000_0040, 0);
      tests_run++;
      if (fl_data !== D_AL1) begin tests_failed++; $display("FAIL alias_high_bits: got %h expected %h", fl_data, D_AL1); end
      run_wb(32'h0000_0040, D_AL2);
      run_fill(32'h0001_007F, 0);
      tests_run++;
      if (fl_data !== D_AL2) begin tests_failed++; $display("FAIL alias_fill_high_addr: got %h expected %h", fl_data, D_AL2); end
      run_fill(32'h0000_007F, 0);
      tests_run++;
      if (fl_data !== D_AL2) begin tests_failed++; $display("FAIL alias_offset_bits: got %h expected %h", fl_data, D_AL2); end
   endtask

   task automatic test_reset_mid();
      bus.fill_req_val  = 1'b1;
      bus.fill_req_addr = 32'h0000_0040;
      @(posedge clk); #1;
      bus.fill_req_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before_reset: got %b expected 1", bus.busy); end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.rd_fill_en !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_fill_en: got %b expected 0", bus.rd_fill_en); end
      tests_run++;
      if (bus.fill_data !== '0) begin tests_failed++; $display("FAIL mid_fill_data: got %h expected 0", bus.fill_data); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.fill_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL mid_fill_req_rdy: got %b expected 0", bus.fill_req_rdy); end
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_fill(32'h0000_0040, 0);
      tests_run++;
      if (fl_lat !== RD_LAT) begin tests_failed++; $display("FAIL post_reset_latency: got %0d expected %0d", fl_lat, RD_LAT); end
      tests_run++;
      if (fl_data !== D_AL2) begin tests_failed++; $display("FAIL post_reset_store_kept: got %h expected %h", fl_data, D_AL2); end
   endtask

   initial begin
      bus.wr_back_val   = 1'b0;
      bus.wr_back_addr  = '0;
      bus.wr_back_data  = '0;
      bus.fill_req_val  = 1'b0;
      bus.fill_req_addr = '0;
      bus.data_in_rdy   = 1'b0;

      test_reset();
      test_writeback();
      test_fill_fast();
      test_fill_stall();
      test_priority();
      test_alias();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
      $fatal(1);
   end

endmodule
`default_nettype wire
